// File: rtl/sync_fifo_flags_pkg.sv
// rtl/sync_fifo_flags_pkg.sv - shared sizing helpers and parameter checks for sync_fifo_flags
//
// Purpose : pointer width, depth and threshold-legality helpers shared by the
//           FIFO top level and its storage sub-module.
// Ports   : none (package).
package sync_fifo_flags_pkg;

   localparam int DEFAULT_DEPTH_LOG = 8;
   localparam int DEPTH             = 2 ** DEFAULT_DEPTH_LOG;

   // Pointers carry one extra wrap bit above the RAM address bits.
   function automatic int ptr_width(input int depth_log);
      return depth_log + 1;
   endfunction

   function automatic int fifo_depth(input int depth_log);
      return 2 ** depth_log;
   endfunction

   // afull threshold must be 1..DEPTH, aempty threshold 0..DEPTH-1.
   function automatic bit thresholds_legal(input int depth_log, input int afull_th,
                                           input int aempty_th);
      int d;
      d = fifo_depth(depth_log);
      return (afull_th >= 1) && (afull_th <= d) && (aempty_th >= 0) && (aempty_th <= d - 1);
   endfunction

endpackage

// File: rtl/sync_fifo_flags_ram.sv
// rtl/sync_fifo_flags_ram.sv - simple dual-port RAM with registered read port
//
// Purpose : FIFO storage. One write port, one read port, read data registered.
// Ports   : clk, rst_n (async active-low, clears only the read register)
//           ram_write_req/addr/data - write port
//           ram_read_req/addr       - read request; data appears next cycle
//           ram_read_data           - registered read data, holds when no request
module fifo_dual_ram #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ram_write_req,
   input  logic [DEPTH_LOG-1:0] ram_write_addr,
   input  logic [WIDTH-1:0]     ram_write_data,
   input  logic                 ram_read_req,
   input  logic [DEPTH_LOG-1:0] ram_read_addr,
   output logic [WIDTH-1:0]     ram_read_data
);

   logic [WIDTH-1:0] mem [2**DEPTH_LOG];

   // Array is deliberately not reset so it can map onto a RAM macro.
   always_ff @(posedge clk) begin
      if (ram_write_req) begin
         mem[ram_write_addr] <= ram_write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_read_data <= '0;
      end else if (ram_read_req) begin
         ram_read_data <= mem[ram_read_addr];
      end
   end

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, threshold flags, flush and sticky errors
//
// Purpose : buffering between producer/consumer stages.
// Ports   : clk, rst_n (async active-low), clr (sync flush, also clears errors)
//           wr_req, wr_data, wr_full, wr_afull       - write side
//           rd_req, rd_data, rd_valid, rd_empty,
//           rd_aempty                                - read side (1-cycle latency)
//           count                                    - occupancy 0..DEPTH
//           overflow, underflow                      - sticky error flags
module sync_fifo_flags
   import sync_fifo_flags_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 8,
   parameter int AFULL_TH  = 252,
   parameter int AEMPTY_TH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 wr_req,
   input  logic [WIDTH-1:0]     wr_data,
   output logic                 wr_full,
   output logic                 wr_afull,
   input  logic                 rd_req,
   output logic [WIDTH-1:0]     rd_data,
   output logic                 rd_valid,
   output logic                 rd_empty,
   output logic                 rd_aempty,
   output logic [DEPTH_LOG:0]   count,
   output logic                 overflow,
   output logic                 underflow
);

   localparam int PW = ptr_width(DEPTH_LOG);
   localparam logic [PW-1:0] ONE      = PW'(1);
   localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
   localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

   if (!thresholds_legal(DEPTH_LOG, AFULL_TH, AEMPTY_TH)) begin : g_bad_thresholds
      $error("sync_fifo_flags: AFULL_TH/AEMPTY_TH out of legal range");
   end

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          wr_acc;
   logic          rd_acc;

   // Full when the addresses match but the wrap bits differ.
   assign wr_full   = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
   assign rd_empty  = (wr_ptr == rd_ptr);
   assign wr_afull  = (count >= AFULL_C);
   assign rd_aempty = (count <= AEMPTY_C);

   // A flush cycle suppresses both ports so neither RAM nor rd_data changes.
   assign wr_acc = wr_req & ~wr_full & ~clr;
   assign rd_acc = rd_req & ~rd_empty & ~clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ONE;
         if (rd_acc) rd_ptr <= rd_ptr + ONE;
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
         rd_valid  <= rd_acc;
         overflow  <= overflow  | (wr_req & wr_full);
         underflow <= underflow | (rd_req & rd_empty);
      end
   end

   fifo_dual_ram #(
      .WIDTH     (WIDTH),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_ram (
      .clk            (clk),
      .rst_n          (rst_n),
      .ram_write_req  (wr_acc),
      .ram_write_addr (wr_ptr[PW-2:0]),
      .ram_write_data (wr_data),
      .ram_read_req   (rd_acc),
      .ram_read_addr  (rd_ptr[PW-2:0]),
      .ram_read_data  (rd_data)
   );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed self-checking bench for sync_fifo_flags
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       wr_req;
   logic [7:0] wr_data;
   logic       wr_full;
   logic       wr_afull;
   logic       rd_req;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_empty;
   logic       rd_aempty;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sync_fifo_flags #(
      .WIDTH     (8),
      .DEPTH_LOG (3),
      .AFULL_TH  (6),
      .AEMPTY_TH (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .wr_req    (wr_req),
      .wr_data   (wr_data),
      .wr_full   (wr_full),
      .wr_afull  (wr_afull),
      .rd_req    (rd_req),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_empty  (rd_empty),
      .rd_aempty (rd_aempty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given inputs; outputs sampled 1 time unit after the edge.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr_req  = w;
      wr_data = d;
      rd_req  = r;
      clr     = c;
      @(posedge clk);
      #1;
      wr_req = 1'b0;
      rd_req = 1'b0;
      clr    = 1'b0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_count"},     32'(count),     32'd0);
      chk({tag, "_empty"},     32'(rd_empty),  32'd1);
      chk({tag, "_full"},      32'(wr_full),   32'd0);
      chk({tag, "_aempty"},    32'(rd_aempty), 32'd1);
      chk({tag, "_afull"},     32'(wr_afull),  32'd0);
      chk({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
      chk({tag, "_rd_data"},   32'(rd_data),   32'd0);
      chk({tag, "_overflow"},  32'(overflow),  32'd0);
      chk({tag, "_underflow"}, 32'(underflow), 32'd0);
   endtask

   logic [7:0] model[$];
   logic [7:0] exp_d;
   logic       w;
   logic       r;

   initial begin
      rst_n   = 1'b0;
      clr     = 1'b0;
      wr_req  = 1'b0;
      rd_req  = 1'b0;
      wr_data = 8'h00;
      #22;
      chk_reset_values("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill 0x10..0x17
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
         chk("fill_count",  32'(count),    32'(i + 1));
         chk("fill_afull",  32'(wr_afull), (i + 1 >= 6) ? 32'd1 : 32'd0);
         chk("fill_full",   32'(wr_full),  (i == 7) ? 32'd1 : 32'd0);
         chk("fill_aempty", 32'(rd_aempty), (i + 1 <= 1) ? 32'd1 : 32'd0);
      end

      // Write while full
      cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("ovf_count", 32'(count),    32'd8);
      chk("ovf_flag",  32'(overflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      chk("ovf_rd_valid_idle", 32'(rd_valid), 32'd0);

      // Drain
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_valid", 32'(rd_valid), 32'd1);
         chk("drain_data",  32'(rd_data),  32'(8'h10 + 8'(i)));
         chk("drain_count", 32'(count),    32'(7 - i));
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("drained_valid",  32'(rd_valid),  32'd0);
      chk("drained_hold",   32'(rd_data),   32'h17);
      chk("drained_empty",  32'(rd_empty),  32'd1);
      chk("drained_aempty", 32'(rd_aempty), 32'd1);
      chk("drained_ovf",    32'(overflow),  32'd1);

      // Read while empty
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("udf_flag",  32'(underflow), 32'd1);
      chk("udf_valid", 32'(rd_valid),  32'd0);
      chk("udf_count", 32'(count),     32'd0);
      cyc(1'b1, 8'h55, 1'b0, 1'b0);
      chk("w55_count", 32'(count),    32'd1);
      chk("w55_valid", 32'(rd_valid), 32'd0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("r55_valid", 32'(rd_valid), 32'd1);
      chk("r55_data",  32'(rd_data),  32'h55);

      // Simultaneous request at full
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      chk("full2_full", 32'(wr_full), 32'd1);
      cyc(1'b1, 8'h99, 1'b1, 1'b0);
      chk("simfull_count", 32'(count),    32'd7);
      chk("simfull_ovf",   32'(overflow), 32'd1);
      chk("simfull_valid", 32'(rd_valid), 32'd1);
      chk("simfull_data",  32'(rd_data),  32'h20);
      for (int i = 1; i < 8; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("simfull_drain", 32'(rd_data), 32'(8'h20 + 8'(i)));
      end
      chk("simfull_end_count", 32'(count), 32'd0);

      // Flush, then simultaneous request at empty
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_ovf", 32'(overflow),  32'd0);
      chk("clr_udf", 32'(underflow), 32'd0);
      cyc(1'b1, 8'h77, 1'b1, 1'b0);
      chk("simempty_count", 32'(count),     32'd1);
      chk("simempty_valid", 32'(rd_valid),  32'd0);
      chk("simempty_udf",   32'(underflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("simempty_rvalid", 32'(rd_valid), 32'd1);
      chk("simempty_rdata",  32'(rd_data),  32'h77);

      // Wrap-around with a queue model, count kept in 2..5
      cyc(1'b1, 8'h30, 1'b0, 1'b0);
      model.push_back(8'h30);
      cyc(1'b1, 8'h31, 1'b0, 1'b0);
      model.push_back(8'h31);
      for (int i = 0; i < 20; i++) begin
         w = (model.size() < 5) && (i % 4 != 3);
         r = (model.size() > 2) && (i % 2 == 1);
         exp_d = 8'h00;
         if (r) exp_d = model.pop_front();
         if (w) model.push_back(8'h40 + 8'(i));
         cyc(w, 8'h40 + 8'(i), r, 1'b0);
         chk("wrap_count", 32'(count),    32'(model.size()));
         chk("wrap_valid", 32'(rd_valid), 32'(r));
         if (r) chk("wrap_data", 32'(rd_data), 32'(exp_d));
      end
      while (model.size() > 0) begin
         exp_d = model.pop_front();
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("wrap_drain", 32'(rd_data), 32'(exp_d));
      end
      chk("wrap_empty", 32'(rd_empty), 32'd1);

      // Flush together with a write at count=5, overflow=1
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
      cyc(1'b1, 8'hAB, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("preclr_count", 32'(count),    32'd5);
      chk("preclr_ovf",   32'(overflow), 32'd1);
      chk("preclr_data",  32'(rd_data),  32'h52);
      cyc(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("clrwr_count", 32'(count),    32'd0);
      chk("clrwr_empty", 32'(rd_empty), 32'd1);
      chk("clrwr_ovf",   32'(overflow), 32'd0);
      chk("clrwr_valid", 32'(rd_valid), 32'd0);
      chk("clrwr_hold",  32'(rd_data),  32'h52);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("clrwr_dropped_udf",   32'(underflow), 32'd1);
      chk("clrwr_dropped_valid", 32'(rd_valid),  32'd0);

      // Asynchronous reset mid-burst
      cyc(1'b1, 8'h60, 1'b0, 1'b0);
      cyc(1'b1, 8'h61, 1'b0, 1'b0);
      cyc(1'b1, 8'h62, 1'b1, 1'b0);
      chk("burst_valid", 32'(rd_valid), 32'd1);
      chk("burst_data",  32'(rd_data),  32'h60);
      chk("burst_count", 32'(count),    32'd2);
      wr_req  = 1'b1;
      wr_data = 8'h63;
      rd_req  = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_values("async_reset");
      wr_req = 1'b0;
      rd_req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("postrst_valid", 32'(rd_valid),  32'd0);
      chk("postrst_udf",   32'(underflow), 32'd1);
      chk("postrst_count", 32'(count),     32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
